// File: rtl/counter_pkg.sv
// Shared definitions for the up/down counter: direction encoding and
// parameter legality checks used at elaboration time.
package counter_pkg;

  // Direction encoding for the up_dn input.
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  localparam int unsigned WIDTH_MIN = 2;
  localparam int unsigned WIDTH_MAX = 16;

  // The counter width must lie in the supported range.
  function automatic bit width_legal(input int unsigned width);
    return (width >= WIDTH_MIN) && (width <= WIDTH_MAX);
  endfunction

  // The sequence length must be at least 2 and must fit in the counter width.
  function automatic bit modulus_legal(input int unsigned width, input int unsigned modulus);
    return (modulus >= 2) && (longint'(modulus) <= (longint'(1) << width));
  endfunction

endpackage

// File: rtl/dff_ar.sv
// Single-bit D flip-flop with asynchronous active-low reset and a load enable.
module dff_ar (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic d,
  output logic q
);

  // Capture d on enabled rising edges; reset clears the bit at once.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values and simulation order between flops cannot matter.
    if (!rst_n) begin
      q <= 1'b0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mod_updown_counter.sv
// Modulo-N up/down counter with synchronous clear, range-checked parallel
// load, wrap or saturate at the ends, terminal-count flag and registered
// wrap / load-error pulses. All state lives in dff_ar bit cells; the
// next-state logic sits here.
module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MODULUS  = 16,
  parameter int unsigned SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  // Refuse to elaborate with an unsupported width or sequence length.
  if (!width_legal(WIDTH) || !modulus_legal(WIDTH, MODULUS)) begin : g_param_check
    $error("mod_updown_counter: illegal WIDTH=%0d / MODULUS=%0d", WIDTH, MODULUS);
  end

  // Highest reachable count, and the modulus widened by one bit so that
  // MODULUS = 2^WIDTH still compares correctly against load_val.
  localparam logic [WIDTH-1:0] Q_MAX   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
  localparam bit               SAT     = (SATURATE != 0);

  logic [WIDTH-1:0] q_d;
  logic             q_en;
  logic             wrap_d;
  logic             load_err_d;

  // Next count and pulse values, priority clr > load > en > hold.
  always_comb begin
    // NOTE: every output of this block is defaulted first so no path can
    // leave one unassigned and infer a latch.
    q_d        = q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (clr) begin
      q_d = '0;
    end else if (load) begin
      if ({1'b0, load_val} < MOD_EXT) begin
        q_d = load_val;
      end else begin
        q_d        = Q_MAX;
        load_err_d = 1'b1;
      end
    end else if (en) begin
      if (up_dn == DIR_UP) begin
        if (q == Q_MAX) begin
          if (!SAT) begin
            q_d    = '0;
            wrap_d = 1'b1;
          end
        end else begin
          q_d = q + WIDTH'(1);
        end
      end else begin
        if (q == '0) begin
          if (!SAT) begin
            q_d    = Q_MAX;
            wrap_d = 1'b1;
          end
        end else begin
          q_d = q - WIDTH'(1);
        end
      end
    end
  end

  // The count only needs to be written when some action is requested.
  assign q_en = clr | load | en;

  // Terminal count: enabled and sitting at the end for the current direction.
  assign tc = en & ((up_dn == DIR_UP) ? (q == Q_MAX) : (q == '0));

  // One flop per count bit.
  for (genvar i = 0; i < WIDTH; i++) begin : g_q_bit
    dff_ar u_q_bit (
      .clk   (clk),
      .rst_n (rst),
      .en    (q_en),
      .d     (q_d[i]),
      .q     (q[i])
    );
  end

  // Pulse flops load every cycle so each pulse lasts exactly one cycle.
  dff_ar u_wrap (
    .clk   (clk),
    .rst_n (rst),
    .en    (1'b1),
    .d     (wrap_d),
    .q     (wrap)
  );

  dff_ar u_load_err (
    .clk   (clk),
    .rst_n (rst),
    .en    (1'b1),
    .d     (load_err_d),
    .q     (load_err)
  );

endmodule

// File: doc/mod_updown_counter.md
MOD_UPDOWN_COUNTER -- requirements
Module: mod_updown_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4: counter width in bits, legal range 2..16.
REQ-002 SHALL have parameter MODULUS, default 16: count sequence length, legal range 2..2^WIDTH.
REQ-003 SHALL have parameter SATURATE, default 0: 0 = wrap at the ends, 1 = hold at the ends.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low (0 = reset).
REQ-006 SHALL have port en, input, 1 bit: count enable.
REQ-007 SHALL have port up_dn, input, 1 bit: 1 = count up, 0 = count down.
REQ-008 SHALL have port clr, input, 1 bit: synchronous clear to 0.
REQ-009 SHALL have port load, input, 1 bit: synchronous parallel load.
REQ-010 SHALL have port load_val, input, WIDTH bits: value used for a parallel load.
REQ-011 SHALL have port q, output, WIDTH bits: current count, driven from a register.
REQ-012 SHALL have port tc, output, 1 bit: terminal count, combinational.
REQ-013 SHALL have port wrap, output, 1 bit: registered pulse, one cycle long.
REQ-014 SHALL have port load_err, output, 1 bit: registered pulse, one cycle long.

Function
REQ-015 SHALL apply one action per rising clk edge, by priority: clr, then load, then en, else hold.
REQ-016 SHALL set q to 0 on clr=1, regardless of load and en.
REQ-017 SHALL set q to load_val on load=1 with clr=0 when load_val < MODULUS.
REQ-018 SHALL, on the same load with load_val >= MODULUS, set q to MODULUS-1 and pulse load_err=1 for the next cycle.
REQ-019 SHALL, with en=1, clr=0, load=0 and up_dn=1, set q to q+1; q=MODULUS-1 goes to 0 (SATURATE=0) or holds (SATURATE=1).
REQ-020 SHALL, with en=1, clr=0, load=0 and up_dn=0, set q to q-1; q=0 goes to MODULUS-1 (SATURATE=0) or holds (SATURATE=1).
REQ-021 SHALL drive tc=1 exactly when en=1 and q is at the terminal value for the current direction: MODULUS-1 when up, 0 when down.
REQ-022 SHALL drive wrap=1 for exactly the one cycle after a wrap-around edge; wrap SHALL never assert when SATURATE=1.
REQ-023 SHALL hold q and keep wrap=0 when en=0 and clr=0 and load=0.
REQ-024 SHALL treat a direction change between edges as taking effect at the next edge, with no lost or extra count.
REQ-025 SHALL never let q reach a value >= MODULUS.

Reset
REQ-026 SHALL, while rst=0, immediately force q=0, wrap=0 and load_err=0, independent of clk.
REQ-027 SHALL ignore every input while rst=0, including mid-sequence; the first counting edge after rst rises SHALL move from 0.
REQ-028 SHALL release reset on the rising edge of rst; the first state update SHALL occur on the next rising clk edge.

Structure
REQ-029 SHALL place in a shared package counter_pkg: the direction constants DIR_UP=1 and DIR_DN=0, and the parameter legality checks.
REQ-030 SHALL build each state bit from one sub-module dff_ar: a D flip-flop with asynchronous active-low reset and enable; the next-state logic SHALL sit in the parent.
REQ-031 SHALL fail elaboration on illegal WIDTH or MODULUS.

Verification (WIDTH=4, MODULUS=10 unless stated)
REQ-032 SHALL cover: rst=0 for 2 cycles, then en=1, up_dn=1 for 12 cycles -> q = 0,1,...,9,0,1; tc=1 while q=9; wrap=1 only in the cycle after 9->0.
REQ-033 SHALL cover: up_dn=0 from q=2 for 4 cycles -> q = 1,0,9,8; wrap=1 one cycle after 0->9; with SATURATE=1 -> q = 1,0,0,0 and wrap stays 0.
REQ-034 SHALL cover: load=1, load_val=7 -> q=7, load_err=0; then load=1, load_val=12 -> q=9 and load_err pulses once.
REQ-035 SHALL cover: clr=1, load=1 and en=1 in the same cycle from q=5 -> q=0.
REQ-036 SHALL cover: rst pulsed low between clk edges while q=6 -> q=0 immediately, before the next edge; counting resumes from 0.
REQ-037 SHALL cover: en=0 for 5 cycles at q=4 with up_dn toggling -> q stays 4, tc=0, wrap=0.
